hilo_md_unit: RTL and testbench

HILO_MD_UNIT -- requirements
Module: hilo_md_unit

---
 rtl/hilo_md_unit_pkg.sv | 29 ++
 rtl/hilo_md_unit.sv | 118 +++++++++++
 tb/tb_hilo_md_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/hilo_md_unit_pkg.sv
// rtl/hilo_md_unit_pkg.sv - shared md_op encodings, default latencies and HI/LO unit types
package hilo_md_unit_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

  // Multiply/divide ops occupy the unit for several cycles; MTHI/MTLO do not.
  function automatic logic md_is_long(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_mult(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU);
  endfunction

endpackage

// File: rtl/hilo_md_unit.sv
// rtl/hilo_md_unit.sv - multi-cycle multiply/divide unit owning the HI/LO registers
module hilo_md_unit
  import hilo_md_unit_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  md_state_e   state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        div_signed;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] calc_hi;
  logic [31:0] calc_lo;
  logic        calc_we;

  // Result computed from the operands presented in the start cycle; latched at that edge.
  // Signed division is done on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s     = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u     = {32'd0, rs_val} * {32'd0, rt_val};
    div_signed = (md_op == MD_DIV);
    ua         = (div_signed && rs_val[31]) ? -rs_val : rs_val;
    ub         = (div_signed && rt_val[31]) ? -rt_val : rt_val;
    uq         = '0;
    ur         = '0;
    if (ub != 32'd0) begin
      uq = ua / ub;
      ur = ua % ub;
    end
    calc_hi = '0;
    calc_lo = '0;
    calc_we = 1'b1;
    case (md_op)
      MD_MULT: begin
        calc_hi = prod_s[63:32];
        calc_lo = prod_s[31:0];
      end
      MD_MULTU: begin
        calc_hi = prod_u[63:32];
        calc_lo = prod_u[31:0];
      end
      MD_DIV, MD_DIVU: begin
        calc_lo = (div_signed && (rs_val[31] ^ rt_val[31])) ? -uq : uq;
        calc_hi = (div_signed && rs_val[31]) ? -ur : ur;
        calc_we = (rt_val != 32'd0);
      end
      default: calc_we = 1'b0;
    endcase
  end

  // Busy covers the start cycle itself so the stall unit reacts without a bubble.
  always_comb begin
    busy = (start && md_is_long(md_op)) || (state == ST_BUSY);
  end

  // Control FSM, countdown and architectural HI/LO update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      res_hi <= '0;
      res_lo <= '0;
      res_we <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (md_is_long(md_op)) begin
              res_hi <= calc_hi;
              res_lo <= calc_lo;
              res_we <= calc_we;
              cnt    <= md_is_mult(md_op) ? 4'(MULT_LAT) : 4'(DIV_LAT);
              state  <= ST_BUSY;
            end else if (md_op == MD_MTHI) begin
              hi <= rs_val;
            end else if (md_op == MD_MTLO) begin
              lo <= rs_val;
            end
          end
        end
        ST_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (res_we) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_md_unit.sv
// tb/tb_hilo_md_unit.sv - self-checking bench for hilo_md_unit
module tb_hilo_md_unit;

  localparam int ML = 5;
  localparam int DL = 10;
  localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2, OP_DIV = 3'd3,
                         OP_DIVU = 3'd4, OP_MTHI = 3'd5, OP_MTLO = 3'd6, OP_BAD = 3'd7;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;

  hilo_md_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation accepted at edge e lands in HI/LO at edge e+LAT.
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
  logic        m_pending, m_we;
  longint      m_edge, m_done;

  function automatic logic is_long(input logic [2:0] op);
    return op >= 3'd1 && op <= 3'd4;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_pending = 0; m_we = 0; m_edge = 0; m_done = 0;
    end else begin
      m_edge++;
      if (m_pending) begin
        if (m_edge == m_done) begin
          if (m_we) begin m_hi = m_res_hi; m_lo = m_res_lo; end
          m_pending = 0;
        end
      end else if (start) begin
        longint a, b, p, q, r;
        case (md_op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            if (md_op == OP_MULT || md_op == OP_DIV) begin
              a = longint'($signed(rs_val)); b = longint'($signed(rt_val));
            end else begin
              a = longint'({32'd0, rs_val}); b = longint'({32'd0, rt_val});
            end
            m_we = 1;
            if (md_op == OP_MULT || md_op == OP_MULTU) begin
              p = a * b;
              m_res_hi = p[63:32]; m_res_lo = p[31:0];
              m_done = m_edge + ML;
            end else begin
              if (b == 0) begin
                m_we = 0; q = 0; r = 0;
              end else begin
                q = a / b; r = a % b;
              end
              m_res_hi = r[31:0]; m_res_lo = q[31:0];
              m_done = m_edge + DL;
            end
            m_pending = 1;
          end
          OP_MTHI: m_hi = rs_val;
          OP_MTLO: m_lo = rs_val;
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
    chk("cyc_busy", {31'd0, busy}, {31'd0, (m_pending || (start && is_long(md_op)))});
  end

  // Issue one op and count how many cycles busy stays high, starting with the start cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int nb);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!busy) break;
      nb++;
      @(posedge clk); #1;
      start = 1'b0; md_op = OP_NONE;
    end
    if (nb == 0) begin
      @(posedge clk); #1;
    end
    start = 1'b0; md_op = OP_NONE;
  endtask

  int nb;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = OP_NONE; rs_val = '0; rt_val = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    run_op(OP_MULT, 32'hFFFFFFFD, 32'd5, nb);
    chk("mult_busy_cycles", nb, 32'd6);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFF1);

    run_op(OP_MULTU, 32'hFFFFFFFF, 32'd2, nb);
    chk("multu_busy_cycles", nb, 32'd6);
    chk("multu_hi", hi, 32'h00000001);
    chk("multu_lo", lo, 32'hFFFFFFFE);

    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, nb);
    chk("div_busy_cycles", nb, 32'd11);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    run_op(OP_DIVU, 32'd7, 32'd0, nb);
    chk("divu0_busy_cycles", nb, 32'd11);
    chk("divu0_hi", hi, 32'hFFFFFFFF);
    chk("divu0_lo", lo, 32'hFFFFFFFD);

    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, nb);
    chk("div_wrap_lo", lo, 32'h80000000);
    chk("div_wrap_hi", hi, 32'h00000000);

    run_op(OP_DIV, 32'd7, 32'hFFFFFFFE, nb);
    chk("div_neg_lo", lo, 32'hFFFFFFFD);
    chk("div_neg_hi", hi, 32'h00000001);

    run_op(OP_DIVU, 32'd100, 32'd7, nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    run_op(OP_MTHI, 32'h12345678, 32'd0, nb);
    chk("mthi_busy_cycles", nb, 32'd0);
    chk("mthi_hi", hi, 32'h12345678);

    run_op(OP_MTLO, 32'hCAFEF00D, 32'd0, nb);
    chk("mtlo_lo", lo, 32'hCAFEF00D);

    run_op(OP_BAD, 32'h11111111, 32'd0, nb);
    run_op(OP_NONE, 32'h22222222, 32'd0, nb);
    chk("noop_hi", hi, 32'h12345678);
    chk("noop_lo", lo, 32'hCAFEF00D);

    // Start pulses while a DIV is in flight must be ignored.
    @(posedge clk); #1;
    start = 1'b1; md_op = OP_DIV; rs_val = 32'd100; rt_val = 32'hFFFFFFF9;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; md_op = OP_MTHI; rs_val = 32'hDEADBEEF;
    @(posedge clk); #1;
    md_op = OP_MULT; rs_val = 32'd3; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    repeat (DL) @(posedge clk);
    #1;
    chk("ignored_busy", {31'd0, busy}, 32'd0);
    chk("ignored_lo", lo, 32'hFFFFFFF2);
    chk("ignored_hi", hi, 32'h00000002);

    // Reset three cycles into a DIV: outputs clear at once and nothing lands later.
    @(posedge clk); #1;
    start = 1'b1; md_op = OP_DIV; rs_val = 32'd50; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_hi", hi, 32'h0);
    chk("async_rst_lo", lo, 32'h0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b1; md_op = OP_MTLO; rs_val = 32'hA5A5A5A5;
    @(posedge clk); #1;
    start = 1'b0; md_op = OP_NONE;
    chk("post_rst_mtlo", lo, 32'hA5A5A5A5);
    repeat (DL + 2) @(posedge clk);
    #1;
    chk("no_late_hi", hi, 32'h0);
    chk("no_late_lo", lo, 32'hA5A5A5A5);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
